// File: rtl/bb_sgpio_rx_if.sv
// SGPIO serial link bundle: clock, frame marker and data from the baseboard transmitter.
interface bb_sgpio_rx_if;
  logic SGPIO_CK;
  logic SGPIO_LD;
  logic SGPIO_DATA;

  modport master (output SGPIO_CK, output SGPIO_LD, output SGPIO_DATA);
  modport slave  (input  SGPIO_CK, input  SGPIO_LD, input  SGPIO_DATA);
endinterface

// File: rtl/bb_sgpio_rx.sv
// SGPIO target-side receiver: deserializes ACT/LOC/FAIL bit triplets per drive and
// commits only complete, LD-framed streams to the active-low drive-bay LED registers.
module bb_sgpio_rx #(
  parameter int          HDD_NUM     = 36,
  parameter int unsigned TIMEOUT_CYC = 250000
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  bb_sgpio_rx_if.slave       sgpio,
  output logic [HDD_NUM-1:0] ACT_LED_N,
  output logic [HDD_NUM-1:0] LOC_LED_N,
  output logic [HDD_NUM-1:0] FAIL_LED_N,
  output logic               FRAME_DONE,
  output logic               FRAME_ERR,
  output logic               LINK_UP
);

  localparam int          NBITS   = 3 * HDD_NUM;
  localparam logic [7:0]  LAST_B  = 8'(NBITS - 1);
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYC);

  typedef enum logic {HUNT, SHIFT} state_t;

  logic [1:0] ck_sync_q, ld_sync_q, dat_sync_q;
  logic [2:0] ck_hist_q;
  logic       ld_d1_q, dat_d1_q;
  logic       ck_f;

  state_t       state_q, state_d;
  logic [7:0]   b_q, b_d;
  logic [31:0]  tmo_q, tmo_d;
  logic         tmo_hit;
  logic         wr_en, commit, err;
  logic         link_q, done_q, err_q;
  logic [NBITS-1:0]   shreg_q, frame_d;
  logic [HDD_NUM-1:0] act_q, loc_q, fail_q;
  logic [HDD_NUM-1:0] act_d, loc_d, fail_d;

  // Stage: 2-flop synchronizers, then CK history with LD/DATA held aligned to D1
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ck_sync_q  <= '0;
      ld_sync_q  <= '0;
      dat_sync_q <= '0;
      ck_hist_q  <= '0;
      ld_d1_q    <= 1'b0;
      dat_d1_q   <= 1'b0;
    end else begin
      ck_sync_q  <= {ck_sync_q[0], sgpio.SGPIO_CK};
      ld_sync_q  <= {ld_sync_q[0], sgpio.SGPIO_LD};
      dat_sync_q <= {dat_sync_q[0], sgpio.SGPIO_DATA};
      ck_hist_q  <= {ck_hist_q[1:0], ck_sync_q[1]};
      ld_d1_q    <= ld_sync_q[1];
      dat_d1_q   <= dat_sync_q[1];
    end
  end

  // Requiring two consecutive low samples rejects single-cycle low glitches
  assign ck_f = ck_hist_q[2] & ~ck_hist_q[1] & ~ck_hist_q[0];

  always_comb begin
    if (ck_f)                tmo_d = '0;
    else if (tmo_q != '1)    tmo_d = tmo_q + 32'd1;
    else                     tmo_d = tmo_q;
    tmo_hit = (tmo_d == TMO_LIM) && (tmo_q != TMO_LIM);
  end

  always_comb begin
    frame_d = shreg_q;
    for (int i = 0; i < NBITS; i++) begin
      if (b_q == 8'(i)) frame_d[i] = dat_d1_q;
    end
  end

  always_comb begin
    act_d  = '1;
    loc_d  = '1;
    fail_d = '1;
    for (int k = 0; k < HDD_NUM; k++) begin
      act_d[k]  = ~frame_d[3*k];
      loc_d[k]  = ~frame_d[3*k+1];
      fail_d[k] = ~frame_d[3*k+2];
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    if (ck_f) begin
      unique case (state_q)
        HUNT: begin
          if (ld_d1_q) begin
            state_d = SHIFT;
            b_d     = '0;
          end
        end
        SHIFT: begin
          if (b_q == LAST_B) begin
            b_d = '0;
            if (ld_d1_q) begin
              wr_en  = 1'b1;
              commit = 1'b1;
            end else begin
              err     = 1'b1;
              state_d = HUNT;
            end
          end else if (ld_d1_q) begin
            // Short frame: this LD closes a frame, so realign to bit 0 next
            err = 1'b1;
            b_d = '0;
          end else begin
            wr_en = 1'b1;
            b_d   = b_q + 8'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (tmo_hit) begin
      state_d = HUNT;
      b_d     = '0;
    end
  end

  // Stage: control state, pulses and committed LED registers
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= HUNT;
      b_q     <= '0;
      tmo_q   <= '0;
      link_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      act_q   <= '1;
      loc_q   <= '1;
      fail_q  <= '1;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      tmo_q   <= tmo_d;
      done_q  <= commit;
      err_q   <= err;
      if (ck_f)         link_q <= 1'b1;
      else if (tmo_hit) link_q <= 1'b0;
      if (tmo_hit) begin
        act_q  <= '1;
        loc_q  <= '1;
        fail_q <= '1;
      end else if (commit) begin
        act_q  <= act_d;
        loc_q  <= loc_d;
        fail_q <= fail_d;
      end
    end
  end

  // Every bit is rewritten before a commit, so stale contents never reach the LEDs
  always_ff @(posedge SYSCLK) begin
    if (wr_en) shreg_q <= frame_d;
  end

  assign ACT_LED_N  = act_q;
  assign LOC_LED_N  = loc_q;
  assign FAIL_LED_N = fail_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;
  assign LINK_UP    = link_q;

endmodule

// File: tb/tb_bb_sgpio_rx.sv
// Directed bench for bb_sgpio_rx: scoreboard of expected FRAME_DONE/FRAME_ERR events and LED values.
module tb_bb_sgpio_rx;
  localparam int N   = 36;
  localparam int TMO = 200;

  logic SYSCLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  bb_sgpio_rx_if sif ();

  logic [N-1:0] act_n, loc_n, fail_n;
  logic         done, err, link;

  bb_sgpio_rx #(.HDD_NUM(N), .TIMEOUT_CYC(TMO)) dut (
    .SYSCLK     (SYSCLK),
    .RESET_N    (RESET_N),
    .sgpio      (sif),
    .ACT_LED_N  (act_n),
    .LOC_LED_N  (loc_n),
    .FAIL_LED_N (fail_n),
    .FRAME_DONE (done),
    .FRAME_ERR  (err),
    .LINK_UP    (link)
  );

  typedef struct {
    logic [1:0]   kind;   // 01 = done, 10 = error
    logic [N-1:0] act;
    logic [N-1:0] loc;
    logic [N-1:0] fail;
  } ev_t;

  ev_t          sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] m_act = '1, m_loc = '1, m_fail = '1;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {{(N-1){1'b0}}, got}, {{(N-1){1'b0}}, exp});
  endtask

  task automatic chk_leds(input string tag);
    chk({tag, "_act"},  act_n,  m_act);
    chk({tag, "_loc"},  loc_n,  m_loc);
    chk({tag, "_fail"}, fail_n, m_fail);
  endtask

  task automatic push_done(input logic [N-1:0] a, input logic [N-1:0] l, input logic [N-1:0] f);
    ev_t e;
    m_act = ~a; m_loc = ~l; m_fail = ~f;
    e.kind = 2'b01; e.act = m_act; e.loc = m_loc; e.fail = m_fail;
    sb.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = 2'b10; e.act = m_act; e.loc = m_loc; e.fail = m_fail;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  // CK high 4 cycles, low 6; optional single-cycle low glitch inside the high phase
  task automatic send_bit(input logic d, input logic ld, input logic glitch);
    @(negedge SYSCLK);
    sif.SGPIO_CK = 1'b1; sif.SGPIO_DATA = d; sif.SGPIO_LD = ld;
    if (glitch) begin
      cyc(1); sif.SGPIO_CK = 1'b0; cyc(1); sif.SGPIO_CK = 1'b1; cyc(2);
    end else begin
      cyc(4);
    end
    sif.SGPIO_CK = 1'b0;
    cyc(6);
  endtask

  task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] l, input logic [N-1:0] f,
                            input int nbits, input int ld_pos, input int glitch_pos);
    for (int b = 0; b < nbits; b++) begin
      logic d;
      case (b % 3)
        0:       d = a[b/3];
        1:       d = l[b/3];
        default: d = f[b/3];
      endcase
      send_bit(d, b == ld_pos, b == glitch_pos);
    end
  endtask

  always @(negedge SYSCLK) begin
    if (RESET_N && (done || err)) begin
      ev_t e;
      if (sb.size() > 0) begin
        e = sb.pop_front();
      end else begin
        e.kind = 2'b00; e.act = '0; e.loc = '0; e.fail = '0;
      end
      chk("evt_kind", {{(N-2){1'b0}}, err, done}, {{(N-2){1'b0}}, e.kind});
      chk("evt_act",  act_n,  e.act);
      chk("evt_loc",  loc_n,  e.loc);
      chk("evt_fail", fail_n, e.fail);
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    sif.SGPIO_CK = 1'b1; sif.SGPIO_LD = 1'b0; sif.SGPIO_DATA = 1'b0;
    RESET_N = 1'b0;
    cyc(3);
    chk("rst_act", act_n, '1);
    chk("rst_loc", loc_n, '1);
    chk("rst_fail", fail_n, '1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_link", link, 1'b0);
    RESET_N = 1'b1;
    cyc(5);

    // Alignment LD only: no event, link comes up
    send_bit(1'b0, 1'b1, 1'b0);
    chk1("align_link", link, 1'b1);
    chk("align_act", act_n, '1);

    push_done(36'h5_A5A5_A5A5, '0, '0);
    send_frame(36'h5_A5A5_A5A5, '0, '0, 108, 107, -1);
    chk("good_act_abs", act_n, 36'hA_5A5A_5A5A);
    chk("good_loc_abs", loc_n, '1);
    chk("good_fail_abs", fail_n, '1);
    chk1("good_link", link, 1'b1);

    push_done(36'h1_2345_6789, 36'hF_0000_000F, 36'h8_0000_0001);
    send_frame(36'h1_2345_6789, 36'hF_0000_000F, 36'h8_0000_0001, 108, 107, -1);
    chk_leds("good2");

    // Short frame: LD on bit 50
    push_err();
    send_frame(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 51, 50, -1);
    chk_leds("short_hold");
    push_done(36'h0_0F0F_0F0F, 36'h3_3333_3333, 36'hC_0000_0000);
    send_frame(36'h0_0F0F_0F0F, 36'h3_3333_3333, 36'hC_0000_0000, 108, 107, -1);
    chk_leds("after_short");

    // Overrun: no LD on bit 107, then a realign-only frame, then a commit
    push_err();
    send_frame(36'hA_AAAA_AAAA, 36'h5_5555_5555, '0, 108, -1, -1);
    send_frame(36'h1_1111_1111, 36'h2_2222_2222, 36'h4_4444_4444, 108, 107, -1);
    chk_leds("overrun_realign");
    push_done(36'h7_6543_210F, 36'h0_0000_0001, 36'h8_0000_0000);
    send_frame(36'h7_6543_210F, 36'h0_0000_0001, 36'h8_0000_0000, 108, 107, -1);
    chk_leds("after_overrun");

    // Glitch in the high phase of bit 20
    push_done(36'hC_3C3C_3C3C, 36'h0_FFFF_0000, 36'h1_0101_0101);
    send_frame(36'hC_3C3C_3C3C, 36'h0_FFFF_0000, 36'h1_0101_0101, 108, 107, 20);
    chk_leds("glitch");

    // Clock loss mid-frame
    send_frame('1, '1, '1, 40, -1, -1);
    sif.SGPIO_CK = 1'b1;
    cyc(TMO + 40);
    m_act = '1; m_loc = '1; m_fail = '1;
    chk1("tmo_link", link, 1'b0);
    chk_leds("tmo_off");
    send_bit(1'b0, 1'b1, 1'b0);
    chk1("tmo_relink", link, 1'b1);
    chk_leds("tmo_still_off");
    push_done(36'h9_8765_4321, 36'h0_0000_FFFF, 36'hF_0000_0000);
    send_frame(36'h9_8765_4321, 36'h0_0000_FFFF, 36'hF_0000_0000, 108, 107, -1);
    chk_leds("tmo_recover");
    chk1("tmo_recover_link", link, 1'b1);

    // Reset mid-frame at bit 60
    send_frame('0, '1, '0, 60, -1, -1);
    @(posedge SYSCLK);
    #2 RESET_N = 1'b0;
    #1;
    m_act = '1; m_loc = '1; m_fail = '1;
    chk_leds("rstmid");
    chk1("rstmid_link", link, 1'b0);
    chk1("rstmid_done", done, 1'b0);
    cyc(3);
    RESET_N = 1'b1;
    cyc(3);
    send_frame('0, '1, '0, 48, 47, -1);
    chk_leds("rstmid_hunt");
    push_done(36'h2_4681_3579, 36'h1_0000_0000, 36'h0_0000_0002);
    send_frame(36'h2_4681_3579, 36'h1_0000_0000, 36'h0_0000_0002, 108, 107, -1);
    chk_leds("rstmid_recover");

    cyc(20);
    chk("sb_drained", N'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bb_sgpio_rx.md
# bb_sgpio_rx

Baseboard SGPIO target-side receiver. It deserializes the 3-bit-per-drive SGPIO stream (SGPIO_CK / SGPIO_LD / SGPIO_DATA) produced by the baseboard SGPIO transmitter. It latches complete, correctly framed bit-streams into per-drive activity, locate and fail LED registers. It sits on the backplane/LED-board side, with its outputs driving the drive-bay LEDs directly.

## Interface
- HDD_NUM, 36 — drives per frame; legal range 1..64; frame length is 3*HDD_NUM bits.
- TIMEOUT_CYC, 250000 — SYSCLK cycles without a filtered CK falling edge before the link is declared down.
- SYSCLK in 1 — system clock; all logic runs on its rising edge.
- RESET_N in 1 — reset, asynchronous, active-low.
- SGPIO_CK in 1 — serial clock; asynchronous to SYSCLK.
- SGPIO_LD in 1 — frame marker; high during the last bit of a frame.
- SGPIO_DATA in 1 — serial data; changes after CK rise, stable at CK fall.
- ACT_LED_N out HDD_NUM — per-drive activity LED, active-low.
- LOC_LED_N out HDD_NUM — per-drive locate LED, active-low.
- FAIL_LED_N out HDD_NUM — per-drive fail LED, active-low.
- FRAME_DONE out 1 — 1-cycle pulse when a good frame is committed.
- FRAME_ERR out 1 — 1-cycle pulse when a frame is discarded.
- LINK_UP out 1 — high while CK edges arrive within TIMEOUT_CYC.

## Operation
- **Input synchronization**
  - CK, LD and DATA each pass through an identical 2-flop synchronizer.
  - CK then feeds a 3-stage history D3/D2/D1.
  - Filtered falling edge CK_F = D3 & ~D2 & ~D1. A low glitch of one SYSCLK cycle is ignored.
  - LD and DATA are taken at the CK_F cycle from the synchronizer stage aligned with D1.
- **Bit mapping** (bit index b counts from 0 after the previous LD bit)
  - b = 3k → ACT of drive k.
  - b = 3k+1 → LOC of drive k.
  - b = 3k+2 → FAIL of drive k.
  - Serial 1 = LED on, so the corresponding output is driven 0.
- **Shift register**: 3*HDD_NUM bits. On each CK_F, the sampled DATA is written at index b.
- **Bit counter**: 8-bit, b.
- **State HUNT**
  - Entered from reset, after a timeout, or after an overrun.
  - Sampled bits are ignored.
  - CK_F with LD=1 → SHIFT with b=0. No commit and no FRAME_ERR on this transition.
- **State SHIFT**, on each CK_F:
  - LD=1 and b = 3*HDD_NUM-1:
    - Store the bit.
    - Next cycle, copy the whole register to the output registers and pulse FRAME_DONE.
    - b ← 0; stay in SHIFT.
  - LD=1 and b ≠ 3*HDD_NUM-1 (short frame):
    - Pulse FRAME_ERR; outputs hold their last committed value.
    - b ← 0; stay in SHIFT, resynchronized on this LD.
  - LD=0 and b = 3*HDD_NUM-1 (overrun, no LD on last bit):
    - Pulse FRAME_ERR → HUNT.
  - Otherwise: b ← b+1.
- **Timeout**
  - A 32-bit counter clears on every CK_F and increments otherwise, saturating.
  - When the count reaches TIMEOUT_CYC:
    - LINK_UP ← 0.
    - All LED outputs are forced to 1 (off).
    - State → HUNT; b ← 0.
    - No FRAME_ERR is generated.
  - LINK_UP ← 1 on the first CK_F after a timeout. LEDs stay off until the next good commit.
- **Simultaneous events**: CK_F in the same cycle as the timeout threshold → the CK_F wins (counter clears, no timeout).

## Timing
- **Reset values**
  - ACT_LED_N, LOC_LED_N, FAIL_LED_N: all 1s.
  - FRAME_DONE, FRAME_ERR, LINK_UP: 0.
  - State HUNT; b = 0; timeout counter 0.
  - Synchronizer and history flops: 0.
- **Reset mid-frame**: partial data is discarded and the outputs go off immediately, asynchronously.
- **Latency** from the SGPIO_CK pin falling edge to CK_F: 4 SYSCLK cycles (2 synchronizer + 2 filter).
- **Commit**: LED outputs and FRAME_DONE update 1 cycle after the CK_F of the last bit.
- **FRAME_ERR**: asserted 1 cycle after the offending CK_F.
- **Clock ratio**: SGPIO_CK high and low phases must each be ≥ 3 SYSCLK cycles. Slower CK is unbounded, up to TIMEOUT_CYC.
- **Width rules**: b compares against the constant 3*HDD_NUM-1 (≤ 191, fits 8 bits). The timeout counter saturates and does not wrap.

## Test plan
- **Good frame**
  - Stimulus: reset; one alignment LD bit; then HDD_NUM=36 frames where ACT bits = 36'h5_A5A5_A5A5 and LOC=FAIL=0, LD high on bit 107.
  - Response: after the first full frame, ACT_LED_N = 36'hA_5A5A_5A5A, LOC_LED_N and FAIL_LED_N all 1s, FRAME_DONE one pulse per frame, LINK_UP=1.
- **Short frame**
  - Stimulus: after a good frame, LD asserted at bit 50.
  - Response: FRAME_ERR pulse; outputs unchanged; the next 108-bit frame commits normally.
- **Overrun**
  - Stimulus: bit 107 with LD=0.
  - Response: FRAME_ERR; state HUNT; the next LD only realigns, and the commit happens one frame later.
- **Glitch**
  - Stimulus: 1-SYSCLK low pulse on CK during a high phase.
  - Response: no bit consumed; frame still commits with correct data.
- **Clock loss**
  - Stimulus: stop CK for TIMEOUT_CYC cycles mid-frame.
  - Response: LINK_UP falls; all LEDs go to 1; restart with alignment plus a frame → LINK_UP=1 and data committed.
- **Reset mid-frame**
  - Stimulus: RESET_N low at bit 60.
  - Response: outputs immediately at reset values; after release, HUNT behaviour.
